// File: rtl/regfile_scoreboard.sv
// Integer register file with an in-order pending-load queue and per-register busy scoreboard.
// Optional read-port forwarding of same-cycle writes is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int LDQ_DEPTH = 4,
    localparam int AW = $clog2(NREGS),
    localparam int OW = $clog2(XLEN / 8),
    localparam int PW = $clog2(LDQ_DEPTH),
    localparam int CW = $clog2(LDQ_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            alu_wr_en,
    input  logic [AW-1:0]   alu_wr_addr,
    input  logic [XLEN-1:0] alu_wr_data,
    input  logic            ld_iss_valid,
    output logic            ld_iss_ready,
    input  logic [AW-1:0]   ld_iss_rd,
    input  logic [2:0]      ld_iss_op,
    input  logic [OW-1:0]   ld_iss_off,
    input  logic            ld_rsp_valid,
    input  logic [XLEN-1:0] ld_rsp_data,
    output logic [CW-1:0]   ldq_count,
    output logic            err_pulse
);

    logic [XLEN-1:0]  r_regs  [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW-1:0]    r_q_rd  [LDQ_DEPTH];
    logic [2:0]       r_q_op  [LDQ_DEPTH];
    logic [OW-1:0]    r_q_off [LDQ_DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_err;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_head_rd;
    logic             w_ld_we;
    logic [XLEN-1:0]  w_ld_data;
    logic             w_alu_we;
    logic             w_err;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_clr_mask;

    // Shift the returned word down to the addressed byte, then apply the RV load extension.
    // Working at 64 bits and truncating lets LW/LWU/LD collapse to "no extension" when XLEN=32.
    function automatic logic [XLEN-1:0] ld_extend(
        input logic [XLEN-1:0] data,
        input logic [2:0]      op,
        input logic [OW-1:0]   off
    );
        logic [XLEN-1:0] v_sh;
        logic [63:0]     v_w;
        logic [63:0]     v_ext;
        v_sh = data >> {off, 3'b000};
        v_w  = 64'(v_sh);
        case (op)
            3'b000:  v_ext = {{56{v_w[7]}},  v_w[7:0]};
            3'b001:  v_ext = {{48{v_w[15]}}, v_w[15:0]};
            3'b010:  v_ext = {{32{v_w[31]}}, v_w[31:0]};
            3'b100:  v_ext = {56'h0, v_w[7:0]};
            3'b101:  v_ext = {48'h0, v_w[15:0]};
            3'b110:  v_ext = {32'h0, v_w[31:0]};
            default: v_ext = v_w;
        endcase
        return v_ext[XLEN-1:0];
    endfunction

    // Read-port value, optionally forwarding this cycle's writes (load writeback first).
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        if (a == AW'(0)) begin
            v = {XLEN{1'b0}};
        end
`ifdef REGFILE_BYPASS_EN
        else if (w_ld_we && (a == w_head_rd)) begin
            v = w_ld_data;
        end else if (w_alu_we && (a == alu_wr_addr)) begin
            v = alu_wr_data;
        end
`endif
        else begin
            v = r_regs[a];
        end
        return v;
    endfunction

    // Busy bit as seen by decode; a register completing its load this cycle reads free when forwarding.
    function automatic logic read_busy(input logic [AW-1:0] a);
        logic v;
`ifdef REGFILE_BYPASS_EN
        v = r_busy[a] && !(w_ld_we && (a == w_head_rd));
`else
        v = r_busy[a];
`endif
        return v;
    endfunction

    assign w_full       = (r_count == CW'(LDQ_DEPTH));
    assign w_empty      = (r_count == CW'(0));
    assign ld_iss_ready = !w_full && !r_busy[ld_iss_rd];
    assign w_push       = ld_iss_valid && ld_iss_ready;
    assign w_pop        = ld_rsp_valid && !w_empty;
    assign w_head_rd    = r_q_rd[r_rptr];
    assign w_ld_we      = w_pop && (w_head_rd != AW'(0));
    assign w_ld_data    = ld_extend(ld_rsp_data, r_q_op[r_rptr], r_q_off[r_rptr]);
    assign w_alu_we     = alu_wr_en && (alu_wr_addr != AW'(0));

    // Protocol errors: ALU write racing an outstanding load, or a response with nothing pending.
    assign w_err = (w_alu_we && r_busy[alu_wr_addr])
                 || (w_alu_we && w_ld_we && (alu_wr_addr == w_head_rd))
                 || (ld_rsp_valid && w_empty);

    assign w_set_mask = (w_push && (ld_iss_rd != AW'(0))) ? (NREGS'(1) << ld_iss_rd) : {NREGS{1'b0}};
    assign w_clr_mask = w_ld_we ? (NREGS'(1) << w_head_rd) : {NREGS{1'b0}};

    // Combinational read ports.
    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
        rs1_busy = read_busy(rs1_addr);
        rs2_busy = read_busy(rs2_addr);
    end

    assign ldq_count = r_count;
    assign err_pulse = r_err;

    // Architectural register array; the load write is issued last so it wins a same-rd collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= {XLEN{1'b0}};
            end
        end else begin
            if (w_alu_we) begin
                r_regs[alu_wr_addr] <= alu_wr_data;
            end
            if (w_ld_we) begin
                r_regs[w_head_rd] <= w_ld_data;
            end
        end
    end

    // Pending-load queue storage and pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LDQ_DEPTH; i++) begin
                r_q_rd[i]  <= AW'(0);
                r_q_op[i]  <= 3'b000;
                r_q_off[i] <= OW'(0);
            end
            r_wptr  <= PW'(0);
            r_rptr  <= PW'(0);
            r_count <= CW'(0);
        end else begin
            if (w_push) begin
                r_q_rd[r_wptr]  <= ld_iss_rd;
                r_q_op[r_wptr]  <= ld_iss_op;
                r_q_off[r_wptr] <= ld_iss_off;
                r_wptr          <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Busy scoreboard and registered error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= {NREGS{1'b0}};
            r_err  <= 1'b0;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
            r_err  <= w_err;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed steps then randomized traffic against
// a queue-based reference model of the register file, scoreboard and load extension rules.
module tb_regfile_scoreboard;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        alu_wr_en;
    logic [4:0]  alu_wr_addr;
    logic [31:0] alu_wr_data;
    logic        ld_iss_valid, ld_iss_ready;
    logic [4:0]  ld_iss_rd;
    logic [2:0]  ld_iss_op;
    logic [1:0]  ld_iss_off;
    logic        ld_rsp_valid;
    logic [31:0] ld_rsp_data;
    logic [2:0]  ldq_count;
    logic        err_pulse;

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .LDQ_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .alu_wr_en(alu_wr_en), .alu_wr_addr(alu_wr_addr), .alu_wr_data(alu_wr_data),
        .ld_iss_valid(ld_iss_valid), .ld_iss_ready(ld_iss_ready),
        .ld_iss_rd(ld_iss_rd), .ld_iss_op(ld_iss_op), .ld_iss_off(ld_iss_off),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data),
        .ldq_count(ldq_count), .err_pulse(err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rd;
        int op;
        int off;
    } ld_t;

    ld_t         q[$];
    logic [31:0] m_regs [NREGS];
    bit          m_busy [NREGS];
    int          n_cmp;
    int          n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_ext(input int op, input int off, input logic [31:0] d);
        logic [31:0] w;
        w = d >> (8 * off);
        case (op)
            0:       return 32'($signed(w[7:0]));
            1:       return 32'($signed(w[15:0]));
            4:       return w & 32'h0000_00FF;
            5:       return w & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (ld_rsp_valid && q.size() > 0 && q[0].rd == int'(a))
            return ref_ext(q[0].op, q[0].off, ld_rsp_data);
        if (alu_wr_en && alu_wr_addr == a) return alu_wr_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
        if (ld_rsp_valid && q.size() > 0 && q[0].rd == int'(a)) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic exp_ready();
        return (q.size() < DEPTH) && !m_busy[ld_iss_rd];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
        end
        q.delete();
    endtask

    task automatic idle();
        alu_wr_en    = 1'b0;
        ld_iss_valid = 1'b0;
        ld_rsp_valid = 1'b0;
    endtask

    task automatic check_outs();
        chk("rs1_data", rs1_data, exp_data(rs1_addr));
        chk("rs2_data", rs2_data, exp_data(rs2_addr));
        chk("rs1_busy", rs1_busy, exp_busy(rs1_addr));
        chk("rs2_busy", rs2_busy, exp_busy(rs2_addr));
        chk("ld_iss_ready", ld_iss_ready, exp_ready());
        chk("ldq_count", ldq_count, q.size());
    endtask

    // Advance the model by one clock using the currently driven inputs, then check err_pulse.
    task automatic tick();
        bit  push, pop, e;
        ld_t h;
        push = ld_iss_valid && exp_ready();
        pop  = ld_rsp_valid && (q.size() > 0);
        e    = ld_rsp_valid && (q.size() == 0);
        if (alu_wr_en && alu_wr_addr != 5'd0) begin
            if (m_busy[alu_wr_addr]) e = 1'b1;
            if (pop && q[0].rd == int'(alu_wr_addr)) e = 1'b1;
            m_regs[alu_wr_addr] = alu_wr_data;
        end
        if (pop) begin
            h = q.pop_front();
            if (h.rd != 0) begin
                m_regs[h.rd] = ref_ext(h.op, h.off, ld_rsp_data);
                m_busy[h.rd] = 1'b0;
            end
        end
        if (push) begin
            q.push_back('{rd: int'(ld_iss_rd), op: int'(ld_iss_op), off: int'(ld_iss_off)});
            if (ld_iss_rd != 5'd0) m_busy[ld_iss_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("err_pulse", err_pulse, e);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b1;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        alu_wr_addr = 5'd0; alu_wr_data = 32'h0;
        ld_iss_rd = 5'd0; ld_iss_op = 3'd0; ld_iss_off = 2'd0;
        ld_rsp_data = 32'h0;
        idle();
        model_reset();
        #12 reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst_ready", ld_iss_ready, 1'b1);
        chk("rst_count", ldq_count, 3'd0);
        chk("rst_err", err_pulse, 1'b0);
        for (int a = 0; a < NREGS; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            chk("rst_rs1", rs1_data, 32'h0);
            chk("rst_rs2", rs2_data, 32'h0);
        end
        tick();

        // ALU write x5, then write to x0
        alu_wr_en = 1'b1; alu_wr_addr = 5'd5; alu_wr_data = 32'hFFFF_FFF0;
        rs1_addr = 5'd0; rs2_addr = 5'd5;
        #1 check_outs();
        tick();
        idle();
        rs1_addr = 5'd5;
        #1 chk("x5_read", rs1_data, 32'hFFFF_FFF0);
        alu_wr_en = 1'b1; alu_wr_addr = 5'd0; alu_wr_data = 32'h7;
        tick();
        idle();
        rs1_addr = 5'd0;
        #1 chk("x0_read", rs1_data, 32'h0);

        // LB then LBU to x3 at byte offset 2
        for (int k = 0; k < 2; k++) begin
            ld_iss_valid = 1'b1; ld_iss_rd = 5'd3;
            ld_iss_op = (k == 0) ? 3'b000 : 3'b100; ld_iss_off = 2'd2;
            rs1_addr = 5'd3;
            #1 check_outs();
            tick();
            idle();
            #1 chk("ld_busy_set", rs1_busy, 1'b1);
            ld_rsp_valid = 1'b1; ld_rsp_data = 32'h0080_0000;
            #1 check_outs();
            tick();
            idle();
            #1;
            chk("ld_result", rs1_data, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            chk("ld_busy_clr", rs1_busy, 1'b0);
        end

        // Fill the queue with loads to x1..x4
        for (int r = 1; r <= 4; r++) begin
            ld_iss_valid = 1'b1; ld_iss_rd = 5'(r); ld_iss_op = 3'b010; ld_iss_off = 2'd0;
            #1 check_outs();
            tick();
        end
        ld_iss_rd = 5'd5;
        #1;
        chk("full_count", ldq_count, 3'd4);
        chk("full_ready", ld_iss_ready, 1'b0);
        tick();
        idle();
        for (int r = 1; r <= 4; r++) begin
            ld_rsp_valid = 1'b1; ld_rsp_data = $urandom;
            rs1_addr = 5'(r); rs2_addr = 5'(r);
            #1 check_outs();
            tick();
        end
        idle();
        #1 check_outs();
        chk("drain_count", ldq_count, 3'd0);

        // WAW stall on busy x1, then a response with an empty queue
        ld_iss_valid = 1'b1; ld_iss_rd = 5'd1; ld_iss_op = 3'b001; ld_iss_off = 2'd1;
        tick();
        #1 chk("waw_ready", ld_iss_ready, 1'b0);
        tick();
        idle();
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'h00AB_CD00; rs1_addr = 5'd1;
        #1 check_outs();
        tick();
        ld_rsp_data = 32'h1234_5678;
        tick();
        idle();
        #1 check_outs();

        // ALU write to a busy register, then ALU/load collision on the same rd
        ld_iss_valid = 1'b1; ld_iss_rd = 5'd6; ld_iss_op = 3'b010; ld_iss_off = 2'd0;
        tick();
        idle();
        alu_wr_en = 1'b1; alu_wr_addr = 5'd6; alu_wr_data = 32'h1111_1111;
        tick();
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'h2222_2222; alu_wr_data = 32'h3333_3333;
        rs1_addr = 5'd6;
        #1 check_outs();
        tick();
        idle();
        #1 chk("collide_ld_wins", rs1_data, 32'h2222_2222);

        // Same-cycle visibility of an ALU write on read port 2
        alu_wr_en = 1'b1; alu_wr_addr = 5'd7; alu_wr_data = 32'h14; rs2_addr = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("x7_same_cycle", rs2_data, 32'h14);
`else
        chk("x7_same_cycle", rs2_data, 32'h0);
`endif
        tick();
        idle();
        #1 chk("x7_next_cycle", rs2_data, 32'h14);

        // Reset in the middle of outstanding loads
        for (int r = 8; r <= 9; r++) begin
            ld_iss_valid = 1'b1; ld_iss_rd = 5'(r); ld_iss_op = 3'b000; ld_iss_off = 2'd0;
            tick();
        end
        idle();
        ld_iss_rd = 5'd8; rs1_addr = 5'd8; rs2_addr = 5'd5;
        #1 reset = 1'b1;
        model_reset();
        #1;
        chk("midrst_count", ldq_count, 3'd0);
        chk("midrst_ready", ld_iss_ready, 1'b1);
        chk("midrst_busy", rs1_busy, 1'b0);
        chk("midrst_x5", rs2_data, 32'h0);
        #1 reset = 1'b0;
        tick();
        ld_rsp_valid = 1'b1; ld_rsp_data = 32'hFFFF_FFFF;
        tick();
        idle();
        tick();

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            rs1_addr     = 5'($urandom_range(0, 31));
            rs2_addr     = 5'($urandom_range(0, 31));
            alu_wr_en    = ($urandom_range(0, 3) == 0);
            alu_wr_addr  = 5'($urandom_range(0, 31));
            alu_wr_data  = $urandom;
            ld_iss_valid = ($urandom_range(0, 1) == 1);
            ld_iss_rd    = 5'($urandom_range(0, 31));
            ld_iss_op    = 3'($urandom_range(0, 7));
            ld_iss_off   = 2'($urandom_range(0, 3));
            ld_rsp_valid = ($urandom_range(0, 9) < 4);
            ld_rsp_data  = $urandom;
            #1 check_outs();
            tick();
        end
        idle();
        for (int a = 0; a < NREGS; a++) begin
            rs1_addr = 5'(a);
            #1 chk("final_reg", rs1_data, exp_data(rs1_addr));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
